// File: rtl/uart_pkg.sv
// Shared UART definitions: default frame geometry and the receiver state encoding.
package uart_pkg;

    localparam int UART_DATA_BITS  = 8;
    localparam int UART_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } rx_state_t;

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchroniser for a single asynchronous input. The reset value is a
// parameter so idle-high lines (serial RX) and idle-low controls share one cell.
module uart_bit_sync #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk_out1,
    input  logic rst,
    input  logic async_bit,
    output logic sync_bit
);

    logic meta;

    always_ff @(posedge clk_out1) begin
        if (rst) begin
            meta     <= RESET_VALUE;
            sync_bit <= RESET_VALUE;
        end else begin
            meta     <= async_bit;
            sync_bit <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_deser.sv
// Oversampling UART receiver: validates the start bit at mid-bit, samples data
// LSB first, checks the stop bit and pushes good bytes into the RX FIFO.
module uart_rx_deser
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = UART_DATA_BITS,
    parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
    input  logic                 clk_out1,
    input  logic                 rst,
    input  logic                 rx_en,
    input  logic                 rx_serial_data,
    input  logic                 fifo_full,
    output logic                 wr_en,
    output logic [DATA_BITS-1:0] din,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CNT_W  = $clog2(OVERSAMPLE);
    localparam int BIDX_W = $clog2(DATA_BITS + 1);

    localparam logic [CNT_W-1:0]  MID_CNT  = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIDX_W-1:0] LAST_BIT = BIDX_W'(DATA_BITS - 1);

    rx_state_t             state;
    logic                  rxs;
    logic [CNT_W-1:0]      cnt;
    logic [BIDX_W-1:0]     bidx;
    logic [DATA_BITS-1:0]  sh;

    uart_bit_sync #(
        .RESET_VALUE (1'b1)
    ) u_rx_sync (
        .clk_out1  (clk_out1),
        .rst       (rst),
        .async_bit (rx_serial_data),
        .sync_bit  (rxs)
    );

    // Everything advances on rx_en ticks only, except the break-release wait,
    // which watches the line every cycle. Status pulses clear by default.
    always_ff @(posedge clk_out1) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            bidx      <= '0;
            sh        <= '0;
            din       <= '0;
            wr_en     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;

            case (state)
                IDLE: begin
                    if (rx_en && !rxs) begin
                        state <= START;
                        cnt   <= '0;
                    end
                end

                START: begin
                    if (rx_en) begin
                        if (cnt == MID_CNT) begin
                            cnt <= '0;
                            if (!rxs) begin
                                state <= DATA;
                                bidx  <= '0;
                            end else begin
                                state <= IDLE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                // Sample points sit a full bit period apart, starting from the
                // mid start-bit sample, so each lands in the middle of its bit.
                DATA: begin
                    if (rx_en) begin
                        if (cnt == LAST_CNT) begin
                            cnt  <= '0;
                            sh   <= {rxs, sh[DATA_BITS-1:1]};
                            bidx <= bidx + 1'b1;
                            if (bidx == LAST_BIT) begin
                                state <= STOP;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                STOP: begin
                    if (rx_en) begin
                        if (cnt == LAST_CNT) begin
                            cnt <= '0;
                            if (rxs) begin
                                state <= IDLE;
                                if (fifo_full) begin
                                    overrun <= 1'b1;
                                end else begin
                                    wr_en <= 1'b1;
                                    din   <= sh;
                                end
                            end else begin
                                frame_err <= 1'b1;
                                state     <= WAIT_HIGH;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end

                // A held-low line must go high before another start is accepted,
                // otherwise a break would decode as a stream of 0x00 frames.
                WAIT_HIGH: begin
                    if (rxs) begin
                        state <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx_deser.sv
// Self-checking bench for uart_rx_deser: a serial line driver plus a frame-level
// reference model that predicts the ordered list of write/error/overrun events.
module tb_uart_rx_deser;

    localparam int EV_WR = 0;
    localparam int EV_FE = 1;
    localparam int EV_OV = 2;

    typedef struct {
        int         kind;
        logic [7:0] data;
        longint     tick;
    } ev_t;

    logic       clk_out1       = 1'b0;
    logic       rst            = 1'b1;
    logic       rx_en          = 1'b0;
    logic       rx_serial_data = 1'b1;
    logic       fifo_full      = 1'b0;
    logic       wr_en;
    logic       frame_err;
    logic       overrun;
    logic [7:0] din;

    int         checks      = 0;
    int         errors      = 0;
    int         tick_period = 27;
    int         div         = 0;
    longint     tick_count  = 0;
    int         multi_hot   = 0;
    logic [7:0] last_din    = 8'h00;
    ev_t        obs_q[$];
    ev_t        exp_q[$];

    uart_rx_deser #(
        .DATA_BITS  (8),
        .OVERSAMPLE (16)
    ) dut (
        .clk_out1       (clk_out1),
        .rst            (rst),
        .rx_en          (rx_en),
        .rx_serial_data (rx_serial_data),
        .fifo_full      (fifo_full),
        .wr_en          (wr_en),
        .din            (din),
        .frame_err      (frame_err),
        .overrun        (overrun)
    );

    always #5 clk_out1 = ~clk_out1;

    // Oversample tick generator, updated on the falling edge so it is stable at the rising edge.
    initial begin
        forever begin
            @(negedge clk_out1);
            if (div >= tick_period - 1) begin
                div   = 0;
                rx_en = 1'b1;
            end else begin
                div   = div + 1;
                rx_en = 1'b0;
            end
        end
    end

    always @(posedge clk_out1) begin
        if (rx_en) tick_count <= tick_count + 1;
    end

    // Event monitor: records every output pulse with its tick stamp.
    always @(negedge clk_out1) begin
        ev_t ev;
        if (int'(wr_en === 1'b1) + int'(frame_err === 1'b1) + int'(overrun === 1'b1) > 1)
            multi_hot++;
        ev.tick = tick_count;
        if (wr_en === 1'b1) begin
            ev.kind = EV_WR; ev.data = din; obs_q.push_back(ev);
        end
        if (frame_err === 1'b1) begin
            ev.kind = EV_FE; ev.data = 8'h00; obs_q.push_back(ev);
        end
        if (overrun === 1'b1) begin
            ev.kind = EV_OV; ev.data = 8'h00; obs_q.push_back(ev);
        end
    end

    // Frame-level model: what a receiver must report for one transmitted frame.
    function automatic void model_frame(input logic [7:0] data, input logic stop_val,
                                        input logic full);
        ev_t e;
        e.data = 8'h00;
        e.tick = 0;
        if (!stop_val) begin
            e.kind = EV_FE;
        end else if (full) begin
            e.kind = EV_OV;
        end else begin
            e.kind   = EV_WR;
            e.data   = data;
            last_din = data;
        end
        exp_q.push_back(e);
    endfunction

    task automatic wait_ticks(input int n);
        int seen = 0;
        while (seen < n) begin
            @(posedge clk_out1);
            if (rx_en) seen++;
        end
        @(negedge clk_out1);
    endtask

    // Drift of +/-1 on bits 1, 3 and 5 gives +/-3 ticks cumulative by the stop bit.
    task automatic send_frame(input logic [7:0] data, input logic stop_val,
                              input logic full_at_stop, input int drift, input logic noise);
        rx_serial_data = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 8; i++) begin
            rx_serial_data = data[i];
            if (noise) fifo_full = ($urandom_range(0, 1) != 0);
            wait_ticks(16 + ((i == 1 || i == 3 || i == 5) ? drift : 0));
        end
        rx_serial_data = stop_val;
        fifo_full      = full_at_stop;
        wait_ticks(16);
        fifo_full = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk_out1);
        checks++;
        if (wr_en !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr_en: got %b, expected 0", wr_en); end
        checks++;
        if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %b, expected 0", frame_err); end
        checks++;
        if (overrun !== 1'b0) begin errors++; $display("[TB] FAIL reset_overrun: got %b, expected 0", overrun); end
        checks++;
        if (din !== 8'h00) begin errors++; $display("[TB] FAIL reset_din: got %02h, expected 00", din); end
        rst = 1'b0;
        @(negedge clk_out1);
        wait_ticks(2);
    endtask

    task automatic test_single();
        obs_q.delete(); exp_q.delete();
        model_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'h55, 1'b1, 1'b0, 0, 1'b0);
        wait_ticks(4);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("[TB] FAIL single_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].data !== exp_q[i].data) begin
                errors++;
                $display("[TB] FAIL single_event%0d: got kind %0d data %02h, expected kind %0d data %02h",
                         i, obs_q[i].kind, obs_q[i].data, exp_q[i].kind, exp_q[i].data);
            end
        end
        wait_ticks(20);
        checks++;
        if (din !== last_din) begin errors++; $display("[TB] FAIL single_din_hold: got %02h, expected %02h", din, last_din); end
    endtask

    task automatic test_back_to_back();
        longint gap;
        obs_q.delete(); exp_q.delete();
        model_frame(8'hA3, 1'b1, 1'b0);
        model_frame(8'h00, 1'b1, 1'b0);
        send_frame(8'hA3, 1'b1, 1'b0, 0, 1'b0);
        send_frame(8'h00, 1'b1, 1'b0, 0, 1'b0);
        wait_ticks(4);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("[TB] FAIL b2b_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].data !== exp_q[i].data) begin
                errors++;
                $display("[TB] FAIL b2b_event%0d: got kind %0d data %02h, expected kind %0d data %02h",
                         i, obs_q[i].kind, obs_q[i].data, exp_q[i].kind, exp_q[i].data);
            end
        end
        if (obs_q.size() == 2) begin
            gap = obs_q[1].tick - obs_q[0].tick;
            checks++;
            if (gap < 159 || gap > 161) begin
                errors++; $display("[TB] FAIL b2b_spacing: got %0d ticks, expected 160+/-1", gap);
            end
        end
    endtask

    task automatic test_glitch();
        obs_q.delete(); exp_q.delete();
        rx_serial_data = 1'b0;
        wait_ticks(4);
        rx_serial_data = 1'b1;
        wait_ticks(20);
        checks++;
        if (obs_q.size() !== 0) begin
            errors++; $display("[TB] FAIL glitch_quiet: got %0d events, expected 0", obs_q.size());
        end
        model_frame(8'h3C, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0, 0, 1'b0);
        wait_ticks(4);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("[TB] FAIL glitch_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].data !== exp_q[i].data) begin
                errors++;
                $display("[TB] FAIL glitch_event%0d: got kind %0d data %02h, expected kind %0d data %02h",
                         i, obs_q[i].kind, obs_q[i].data, exp_q[i].kind, exp_q[i].data);
            end
        end
    endtask

    task automatic test_frame_error();
        obs_q.delete(); exp_q.delete();
        model_frame(8'h7E, 1'b0, 1'b0);
        send_frame(8'h7E, 1'b0, 1'b0, 0, 1'b0);
        wait_ticks(40);
        rx_serial_data = 1'b1;
        wait_ticks(16);
        checks++;
        if (obs_q.size() !== 1) begin
            errors++; $display("[TB] FAIL ferr_break_count: got %0d events, expected 1", obs_q.size());
        end
        model_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h12, 1'b1, 1'b0, 0, 1'b0);
        wait_ticks(4);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("[TB] FAIL ferr_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].data !== exp_q[i].data) begin
                errors++;
                $display("[TB] FAIL ferr_event%0d: got kind %0d data %02h, expected kind %0d data %02h",
                         i, obs_q[i].kind, obs_q[i].data, exp_q[i].kind, exp_q[i].data);
            end
        end
    endtask

    task automatic test_overrun();
        obs_q.delete(); exp_q.delete();
        model_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1, 0, 1'b0);
        wait_ticks(4);
        checks++;
        if (din !== last_din) begin errors++; $display("[TB] FAIL ovr_din_kept: got %02h, expected %02h", din, last_din); end
        model_frame(8'h0F, 1'b1, 1'b0);
        send_frame(8'h0F, 1'b1, 1'b0, 0, 1'b0);
        wait_ticks(4);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("[TB] FAIL ovr_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].data !== exp_q[i].data) begin
                errors++;
                $display("[TB] FAIL ovr_event%0d: got kind %0d data %02h, expected kind %0d data %02h",
                         i, obs_q[i].kind, obs_q[i].data, exp_q[i].kind, exp_q[i].data);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'h99;
        obs_q.delete(); exp_q.delete();
        rx_serial_data = 1'b0;
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            rx_serial_data = b[i];
            wait_ticks(16);
        end
        rx_serial_data = b[4];
        wait_ticks(8);
        rst = 1'b1;
        @(negedge clk_out1);
        rst = 1'b0;
        rx_serial_data = 1'b1;
        last_din = 8'h00;
        wait_ticks(40);
        checks++;
        if (obs_q.size() !== 0) begin
            errors++; $display("[TB] FAIL rstmid_quiet: got %0d events, expected 0", obs_q.size());
        end
        checks++;
        if (din !== last_din) begin errors++; $display("[TB] FAIL rstmid_din: got %02h, expected %02h", din, last_din); end
        model_frame(b, 1'b1, 1'b0);
        send_frame(b, 1'b1, 1'b0, 0, 1'b0);
        wait_ticks(4);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("[TB] FAIL rstmid_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].data !== exp_q[i].data) begin
                errors++;
                $display("[TB] FAIL rstmid_event%0d: got kind %0d data %02h, expected kind %0d data %02h",
                         i, obs_q[i].kind, obs_q[i].data, exp_q[i].kind, exp_q[i].data);
            end
        end
    endtask

    task automatic test_random();
        logic [7:0] data;
        logic       stop_val;
        logic       full;
        int         drift;
        int         gap;
        obs_q.delete(); exp_q.delete();
        for (int f = 0; f < 12; f++) begin
            data     = 8'($urandom);
            stop_val = ($urandom_range(0, 3) != 0);
            full     = ($urandom_range(0, 3) == 0);
            drift    = int'($urandom_range(0, 2)) - 1;
            gap      = int'($urandom_range(0, 3));
            model_frame(data, stop_val, full);
            send_frame(data, stop_val, full, drift, 1'b1);
            if (!stop_val) begin
                rx_serial_data = 1'b1;
                wait_ticks(2 + gap);
            end else if (gap > 0) begin
                wait_ticks(gap);
            end
        end
        wait_ticks(4);
        checks++;
        if (obs_q.size() !== exp_q.size()) begin
            errors++; $display("[TB] FAIL random_count: got %0d events, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            checks++;
            if (obs_q[i].kind !== exp_q[i].kind || obs_q[i].data !== exp_q[i].data) begin
                errors++;
                $display("[TB] FAIL random_event%0d: got kind %0d data %02h, expected kind %0d data %02h",
                         i, obs_q[i].kind, obs_q[i].data, exp_q[i].kind, exp_q[i].data);
            end
        end
        checks++;
        if (multi_hot !== 0) begin
            errors++; $display("[TB] FAIL one_hot_pulses: got %0d overlapping cycles, expected 0", multi_hot);
        end
    endtask

    initial begin
        @(negedge clk_out1);
        test_reset();
        test_single();
        tick_period = 4;
        wait_ticks(4);
        test_back_to_back();
        test_glitch();
        test_frame_error();
        test_overrun();
        test_reset_mid_frame();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
